// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection and one-cycle bubble insertion.
// Optional hazard statistics counters are enabled by defining HAZARD_STATS_EN.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [1:0]        id_WB_i,
  input  logic [1:0]        id_M_i,
  input  logic [3:0]        id_EX_i,
  input  logic [DATA_W-1:0] id_RsData_i,
  input  logic [DATA_W-1:0] id_RtData_i,
  input  logic [DATA_W-1:0] id_Imm_i,
  input  logic [ADDR_W-1:0] id_RsAddr_i,
  input  logic [ADDR_W-1:0] id_RtAddr_i,
  input  logic [ADDR_W-1:0] id_RdAddr_i,
  output logic              ex_valid_o,
  output logic [1:0]        ex_WB_o,
  output logic [1:0]        ex_M_o,
  output logic [3:0]        ex_EX_o,
  output logic [DATA_W-1:0] ex_RsData_o,
  output logic [DATA_W-1:0] ex_RtData_o,
  output logic [DATA_W-1:0] ex_Imm_o,
  output logic [ADDR_W-1:0] IDEX_RsAddr_o,
  output logic [ADDR_W-1:0] IDEX_RtAddr_o,
  output logic [ADDR_W-1:0] IDEX_RdAddr_o,
`ifdef HAZARD_STATS_EN
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o,
`endif
  output logic              stall_o
);

  logic                     vld_p1;
  logic [1:0]               wb_p1;
  logic [1:0]               m_p1;
  logic [3:0]               ex_p1;
  logic signed [DATA_W-1:0] rs_data_p1;
  logic signed [DATA_W-1:0] rt_data_p1;
  logic signed [DATA_W-1:0] imm_p1;
  logic [ADDR_W-1:0]        rs_addr_p1;
  logic [ADDR_W-1:0]        rt_addr_p1;
  logic [ADDR_W-1:0]        rd_addr_p1;

  logic hz;
  logic bubble;
  logic live;

  // A load in EX whose destination (never $0) is read by the instruction in ID.
  assign hz = vld_p1 & m_p1[1] & (rt_addr_p1 != '0) & id_valid_i &
              ((rt_addr_p1 == id_RsAddr_i) | (rt_addr_p1 == id_RtAddr_i));

  assign stall_o = hz & ~flush_i & ~hold_i & ~rst_i;
  assign bubble  = flush_i | hz;
  assign live    = id_valid_i & ~bubble;

  // ID -> EX stage boundary
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1     <= 1'b0;
      wb_p1      <= '0;
      m_p1       <= '0;
      ex_p1      <= '0;
      rs_data_p1 <= '0;
      rt_data_p1 <= '0;
      imm_p1     <= '0;
      rs_addr_p1 <= '0;
      rt_addr_p1 <= '0;
      rd_addr_p1 <= '0;
    end else if (!hold_i) begin
      vld_p1     <= live;
      wb_p1      <= live ? id_WB_i : 2'b00;
      m_p1       <= live ? id_M_i  : 2'b00;
      ex_p1      <= live ? id_EX_i : 4'b0000;
      rs_data_p1 <= $signed(id_RsData_i);
      rt_data_p1 <= $signed(id_RtData_i);
      imm_p1     <= $signed(id_Imm_i);
      rs_addr_p1 <= id_RsAddr_i;
      rt_addr_p1 <= id_RtAddr_i;
      rd_addr_p1 <= id_RdAddr_i;
    end
  end

  assign ex_valid_o    = vld_p1;
  assign ex_WB_o       = wb_p1;
  assign ex_M_o        = m_p1;
  assign ex_EX_o       = ex_p1;
  assign ex_RsData_o   = rs_data_p1;
  assign ex_RtData_o   = rt_data_p1;
  assign ex_Imm_o      = imm_p1;
  assign IDEX_RsAddr_o = rs_addr_p1;
  assign IDEX_RtAddr_o = rt_addr_p1;
  assign IDEX_RdAddr_o = rd_addr_p1;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

  // Flush outranks the hazard, so an edge counts toward at most one counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!hold_i) begin
      if (flush_i)
        flush_cnt <= sat_inc(flush_cnt);
      else if (hz)
        stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`endif

endmodule
